seven_seg_scan_decoder: RTL and testbench
=========================================

SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1: consecutive cycles an anode value must be stable before its digit is sampled, legal range 1..15.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024: cycles without a sample in TRACK before the lock is dropped.
REQ-003 The block SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port anode  in  4  digit enables, active-low; 1110 ones, 1101 tens, 1011 hundreds, 0111 thousands, 1111 blank.
REQ-006 The block SHALL have port cathode  in  8  segments, active-low; [7:1] = segments a..g, [0] = decimal point.
REQ-007 The block SHALL have ports ones, tens, hundreds, thousands, each  out  4  committed digit codes.
REQ-008 The block SHALL have port dp  out  4  committed decimal points, active-high; bit i = digit i (0 = ones).
REQ-009 The block SHALL have port frame_stb  out  1  one-cycle pulse, new frame committed.
REQ-010 The block SHALL have port locked  out  1  high after the first committed frame, until an error or timeout.
REQ-011 The block SHALL have ports err_order, err_anode, err_seg, each  out  1  one-cycle error pulses.

Function
REQ-012 anode and cathode SHALL be registered once on entry; all decisions use the registered copies.
REQ-013 A run counter, saturating at 15, SHALL count consecutive cycles with an unchanged registered anode, restarting at 1 on any change.
REQ-014 A sample event SHALL occur exactly once per dwell, in the cycle the run count equals SETTLE, only for the four legal one-hot-low anode values.
REQ-015 Pattern decode (cathode[7:1]) SHALL map 0000001..0000100 to codes 0..9 (driver table: 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8); 1111110 to 4'hE (dash); 1111111 to 4'hB (blank); any other pattern to 4'hF with err_seg pulsed in the sample cycle, frame continuing.
REQ-016 The FSM SHALL have states HUNT and TRACK plus a 2-bit expected index exp.
REQ-017 In HUNT, a sample of ones SHALL capture the ones digit to shadow, set exp=1, and enter TRACK; other samples are ignored.
REQ-018 In TRACK, a sample with index==exp SHALL capture it to shadow and increment exp; on capturing thousands, exp wraps to 0 and the frame commits.
REQ-019 In TRACK, a sample with index!=exp SHALL pulse err_order, clear locked, and discard shadow; if that sample is ones it restarts TRACK with exp=1, otherwise enters HUNT.
REQ-020 A registered anode with two or more low bits SHALL pulse err_anode once per dwell, clear locked, and force HUNT.
REQ-021 Anode 1111 SHALL be tolerated: no sample, no error, no state change, timeout keeps counting.
REQ-022 In TRACK, TIMEOUT cycles without a sample SHALL force HUNT and clear locked, with no error pulse.
REQ-023 Commit SHALL copy all four shadow digits and dp bits to the outputs atomically, pulse frame_stb, and set locked; latency is the thousands pattern on the pins in cycle N -> outputs and frame_stb in cycle N+1+SETTLE.
REQ-024 Committed outputs SHALL hold between commits, including across errors and timeout.

Reset
REQ-025 When rst=1 at an edge, all outputs SHALL be 0 next cycle (digits 0, dp 0, pulses 0, locked 0), the FSM SHALL be HUNT with exp=0, the run and timeout counters and shadow SHALL be 0, and input registers SHALL be 1111/11111111.
REQ-026 Reset mid-frame SHALL discard the partial frame; no frame_stb SHALL be produced for it.

Structure
REQ-027 Package seven_seg_pkg SHALL hold the segment-pattern constants, the anode one-hot constants, codes 4'hB/4'hE/4'hF, and the digit-index type.
REQ-028 Combinational sub-module seven_seg_pattern_decode (cathode[7:1] -> 4-bit code + invalid flag) SHALL be instantiated once.

Verification
REQ-029 The bench SHALL cover: SETTLE=1, rotating driver showing 4,3,2,1 (thousands..ones), two rotations -> first frame_stb after the first thousands dwell, thousands=4, hundreds=3, tens=2, ones=1, locked=1.
REQ-030 The bench SHALL cover: sequence ones, tens, thousands -> err_order pulse on the thousands sample, locked=0, HUNT, outputs unchanged.
REQ-031 The bench SHALL cover: anode=1100 held 3 cycles -> a single err_anode pulse, HUNT.
REQ-032 The bench SHALL cover: cathode[7:1]=1010101 on tens -> err_seg, tens=4'hF after commit, frame_stb still produced.
REQ-033 The bench SHALL cover: SETTLE=3, each anode held 2 cycles -> no samples; held 3 cycles -> normal frame commits.
REQ-034 The bench SHALL cover: rst asserted after ones/tens captured -> all outputs 0 next cycle, no frame_stb, and a clean frame after release.

Source files
------------

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared constants and types for the seven-segment scan decoder:
//               segment patterns (active-low a..g), anode one-hot-low codes,
//               special digit codes and the digit-index / FSM state types.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  // Segment patterns, bit 6 = segment a ... bit 0 = segment g, active-low
  localparam logic [6:0] c_SEG_0     = 7'b0000001;
  localparam logic [6:0] c_SEG_1     = 7'b1001111;
  localparam logic [6:0] c_SEG_2     = 7'b0010010;
  localparam logic [6:0] c_SEG_3     = 7'b0000110;
  localparam logic [6:0] c_SEG_4     = 7'b1001100;
  localparam logic [6:0] c_SEG_5     = 7'b0100100;
  localparam logic [6:0] c_SEG_6     = 7'b0100000;
  localparam logic [6:0] c_SEG_7     = 7'b0001111;
  localparam logic [6:0] c_SEG_8     = 7'b0000000;
  localparam logic [6:0] c_SEG_9     = 7'b0000100;
  localparam logic [6:0] c_SEG_DASH  = 7'b1111110;
  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

  // Anode enables, active-low one-hot
  localparam logic [3:0] c_AN_ONES      = 4'b1110;
  localparam logic [3:0] c_AN_TENS      = 4'b1101;
  localparam logic [3:0] c_AN_HUNDREDS  = 4'b1011;
  localparam logic [3:0] c_AN_THOUSANDS = 4'b0111;
  localparam logic [3:0] c_AN_BLANK     = 4'b1111;

  // Non-numeric digit codes
  localparam logic [3:0] c_CODE_BLANK = 4'hB;
  localparam logic [3:0] c_CODE_DASH  = 4'hE;
  localparam logic [3:0] c_CODE_BAD   = 4'hF;

  typedef enum logic [1:0] {
    DIG_ONES      = 2'd0,
    DIG_TENS      = 2'd1,
    DIG_HUNDREDS  = 2'd2,
    DIG_THOUSANDS = 2'd3
  } digit_idx_t;

  typedef enum logic [0:0] {
    ST_HUNT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seven_seg_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pattern_decode
// Description : Combinational map from an active-low a..g segment pattern to a
//               4-bit digit code; unknown patterns give 4'hF and o_invalid.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_invalid
);

  // Table lookup; anything the driver cannot legally emit is flagged
  always_comb begin
    o_code    = c_CODE_BAD;
    o_invalid = 1'b0;
    case (i_seg)
      c_SEG_0:     o_code = 4'd0;
      c_SEG_1:     o_code = 4'd1;
      c_SEG_2:     o_code = 4'd2;
      c_SEG_3:     o_code = 4'd3;
      c_SEG_4:     o_code = 4'd4;
      c_SEG_5:     o_code = 4'd5;
      c_SEG_6:     o_code = 4'd6;
      c_SEG_7:     o_code = 4'd7;
      c_SEG_8:     o_code = 4'd8;
      c_SEG_9:     o_code = 4'd9;
      c_SEG_DASH:  o_code = c_CODE_DASH;
      c_SEG_BLANK: o_code = c_CODE_BLANK;
      default:     o_invalid = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_decoder
// Description : Snoops a multiplexed 4-digit seven-segment display bus and
//               recovers the shown digits. Each anode dwell is sampled once
//               after SETTLE stable cycles; a full ones..thousands sequence
//               commits a frame atomically.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int SETTLE  = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] anode,
  input  logic [7:0] cathode,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands,
  output logic [3:0] dp,
  output logic       frame_stb,
  output logic       locked,
  output logic       err_order,
  output logic       err_anode,
  output logic       err_seg
);

  localparam int             c_TW       = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
  localparam logic [3:0]     c_SETTLE   = 4'(SETTLE);

  logic [3:0]      r_anode;
  logic [7:0]      r_cathode;
  logic [3:0]      r_run;
  logic            r_fresh;   // r_run took a new value at the last edge
  state_t          r_state,  w_state_n;
  digit_idx_t      r_exp,    w_exp_n;
  logic [c_TW-1:0] r_tmo,    w_tmo_n;
  logic [3:0]      r_sh_ones, r_sh_tens, r_sh_hund;
  logic [3:0]      w_sh_ones_n, w_sh_tens_n, w_sh_hund_n;
  logic [2:0]      r_sh_dp,  w_sh_dp_n;
  logic [3:0]      r_ones, r_tens, r_hund, r_thou, r_dp;
  logic            r_frame_stb, r_locked, r_err_order, r_err_anode, r_err_seg;

  logic [3:0]      w_code;
  logic            w_invalid;
  logic            w_dp_bit;
  digit_idx_t      w_idx;
  logic            w_legal, w_multi, w_sample, w_bad_anode;
  logic            w_commit, w_err_order, w_lock_clr, w_capture, w_clear;

  seven_seg_pattern_decode u_decode (
    .i_seg     (r_cathode[7:1]),
    .o_code    (w_code),
    .o_invalid (w_invalid)
  );

  assign w_dp_bit = ~r_cathode[0];

  // Register the pins and count how long the registered anode has been stable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_anode   <= c_AN_BLANK;
      r_cathode <= 8'hFF;
      r_run     <= 4'd0;
      r_fresh   <= 1'b0;
    end else begin
      r_anode   <= anode;
      r_cathode <= cathode;
      if (anode != r_anode) begin
        r_run   <= 4'd1;
        r_fresh <= 1'b1;
      end else if (r_run != 4'd15) begin
        r_run   <= r_run + 4'd1;
        r_fresh <= 1'b1;
      end else begin
        r_fresh <= 1'b0;
      end
    end
  end

  // Classify the registered anode into a digit index or an illegal enable set
  always_comb begin
    w_idx   = DIG_ONES;
    w_legal = 1'b1;
    case (r_anode)
      c_AN_ONES:      w_idx = DIG_ONES;
      c_AN_TENS:      w_idx = DIG_TENS;
      c_AN_HUNDREDS:  w_idx = DIG_HUNDREDS;
      c_AN_THOUSANDS: w_idx = DIG_THOUSANDS;
      default:        w_legal = 1'b0;
    endcase
  end

  assign w_multi     = !w_legal && (r_anode != c_AN_BLANK);
  // r_fresh keeps a SETTLE of 15 from re-sampling while the counter sits saturated
  assign w_sample    = w_legal && r_fresh && (r_run == c_SETTLE);
  assign w_bad_anode = w_multi && (r_run == 4'd1);

  // Next-state logic: frame tracking, error detection and timeout
  always_comb begin
    w_state_n   = r_state;
    w_exp_n     = r_exp;
    w_tmo_n     = r_tmo;
    w_sh_ones_n = r_sh_ones;
    w_sh_tens_n = r_sh_tens;
    w_sh_hund_n = r_sh_hund;
    w_sh_dp_n   = r_sh_dp;
    w_commit    = 1'b0;
    w_err_order = 1'b0;
    w_lock_clr  = 1'b0;
    w_capture   = 1'b0;
    w_clear     = 1'b0;

    if (w_bad_anode) begin
      w_state_n  = ST_HUNT;
      w_exp_n    = DIG_ONES;
      w_tmo_n    = '0;
      w_lock_clr = 1'b1;
      w_clear    = 1'b1;
    end else if (w_sample) begin
      w_tmo_n = '0;
      if (r_state == ST_HUNT) begin
        if (w_idx == DIG_ONES) begin
          w_capture = 1'b1;
          w_exp_n   = DIG_TENS;
          w_state_n = ST_TRACK;
        end
      end else if (w_idx == r_exp) begin
        if (r_exp == DIG_THOUSANDS) begin
          // Thousands goes straight to the outputs alongside the shadow
          w_commit = 1'b1;
          w_exp_n  = DIG_ONES;
        end else begin
          w_capture = 1'b1;
          w_exp_n   = digit_idx_t'(r_exp + 2'd1);
        end
      end else begin
        w_err_order = 1'b1;
        w_lock_clr  = 1'b1;
        w_clear     = 1'b1;
        if (w_idx == DIG_ONES) begin
          w_capture = 1'b1;
          w_exp_n   = DIG_TENS;
        end else begin
          w_state_n = ST_HUNT;
          w_exp_n   = DIG_ONES;
        end
      end
    end else if (r_state == ST_TRACK) begin
      if (r_tmo == c_TMO_LAST) begin
        w_state_n  = ST_HUNT;
        w_exp_n    = DIG_ONES;
        w_tmo_n    = '0;
        w_lock_clr = 1'b1;
        w_clear    = 1'b1;
      end else begin
        w_tmo_n = r_tmo + c_TW'(1);
      end
    end

    if (w_clear) begin
      w_sh_ones_n = 4'd0;
      w_sh_tens_n = 4'd0;
      w_sh_hund_n = 4'd0;
      w_sh_dp_n   = 3'd0;
    end
    if (w_capture) begin
      case (w_idx)
        DIG_ONES:     begin w_sh_ones_n = w_code; w_sh_dp_n[0] = w_dp_bit; end
        DIG_TENS:     begin w_sh_tens_n = w_code; w_sh_dp_n[1] = w_dp_bit; end
        DIG_HUNDREDS: begin w_sh_hund_n = w_code; w_sh_dp_n[2] = w_dp_bit; end
        default:      ;
      endcase
    end
  end

  // FSM, expected index, timeout counter and shadow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_HUNT;
      r_exp     <= DIG_ONES;
      r_tmo     <= '0;
      r_sh_ones <= 4'd0;
      r_sh_tens <= 4'd0;
      r_sh_hund <= 4'd0;
      r_sh_dp   <= 3'd0;
    end else begin
      r_state   <= w_state_n;
      r_exp     <= w_exp_n;
      r_tmo     <= w_tmo_n;
      r_sh_ones <= w_sh_ones_n;
      r_sh_tens <= w_sh_tens_n;
      r_sh_hund <= w_sh_hund_n;
      r_sh_dp   <= w_sh_dp_n;
    end
  end

  // Committed outputs, lock flag and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ones      <= 4'd0;
      r_tens      <= 4'd0;
      r_hund      <= 4'd0;
      r_thou      <= 4'd0;
      r_dp        <= 4'd0;
      r_frame_stb <= 1'b0;
      r_locked    <= 1'b0;
      r_err_order <= 1'b0;
      r_err_anode <= 1'b0;
      r_err_seg   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_ones <= r_sh_ones;
        r_tens <= r_sh_tens;
        r_hund <= r_sh_hund;
        r_thou <= w_code;
        r_dp   <= {w_dp_bit, r_sh_dp};
      end
      r_frame_stb <= w_commit;
      r_locked    <= w_commit ? 1'b1 : (w_lock_clr ? 1'b0 : r_locked);
      r_err_order <= w_err_order;
      r_err_anode <= w_bad_anode;
      r_err_seg   <= w_sample && w_invalid;
    end
  end

  assign ones      = r_ones;
  assign tens      = r_tens;
  assign hundreds  = r_hund;
  assign thousands = r_thou;
  assign dp        = r_dp;
  assign frame_stb = r_frame_stb;
  assign locked    = r_locked;
  assign err_order = r_err_order;
  assign err_anode = r_err_anode;
  assign err_seg   = r_err_seg;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_decoder
// Description : Self-checking bench. Two instances (SETTLE=1 and SETTLE=3)
//               see the same pins; a dwell-based reference model predicts
//               every output every cycle, plus directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_decoder;

  localparam int c_TMO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] anode = 4'hF;
  logic [7:0] cathode = 8'hFF;

  logic [3:0] s1_ones, s1_tens, s1_hund, s1_thou, s1_dp;
  logic       s1_stb, s1_lock, s1_eo, s1_ea, s1_es;
  logic [3:0] s3_ones, s3_tens, s3_hund, s3_thou, s3_dp;
  logic       s3_stb, s3_lock, s3_eo, s3_ea, s3_es;

  seven_seg_scan_decoder #(.SETTLE(1), .TIMEOUT(c_TMO)) u_dut1 (
    .clk(clk), .rst(rst), .anode(anode), .cathode(cathode),
    .ones(s1_ones), .tens(s1_tens), .hundreds(s1_hund), .thousands(s1_thou),
    .dp(s1_dp), .frame_stb(s1_stb), .locked(s1_lock),
    .err_order(s1_eo), .err_anode(s1_ea), .err_seg(s1_es)
  );

  seven_seg_scan_decoder #(.SETTLE(3), .TIMEOUT(c_TMO)) u_dut3 (
    .clk(clk), .rst(rst), .anode(anode), .cathode(cathode),
    .ones(s3_ones), .tens(s3_tens), .hundreds(s3_hund), .thousands(s3_thou),
    .dp(s3_dp), .frame_stb(s3_stb), .locked(s3_lock),
    .err_order(s3_eo), .err_anode(s3_ea), .err_seg(s3_es)
  );

  always #5 clk = ~clk;

  wire [24:0] w_pk1 = {s1_thou, s1_hund, s1_tens, s1_ones, s1_dp, s1_stb, s1_lock, s1_eo, s1_ea, s1_es};
  wire [24:0] w_pk3 = {s3_thou, s3_hund, s3_tens, s3_ones, s3_dp, s3_stb, s3_lock, s3_eo, s3_ea, s3_es};

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int         settle_of [2] = '{1, 3};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Per-instance event counters for directed scenario checks
  int cnt_stb [2];
  int cnt_eo  [2];
  int cnt_ea  [2];
  int cnt_es  [2];
  int first_stb [2];

  // Reference model state, index 0 = SETTLE 1, index 1 = SETTLE 3
  logic [3:0] m_pan  [2];
  logic [7:0] m_pcat [2];
  int         m_d    [2];
  bit         m_track[2];
  int         m_exp  [2];
  int         m_tmo  [2];
  logic [3:0] m_sh   [2][4];
  bit         m_shdp [2][4];
  logic [3:0] m_dig  [2][4];
  bit         m_dpo  [2][4];
  bit         m_stb[2], m_lock[2], m_eo[2], m_ea[2], m_es[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic decode(input logic [6:0] p, output logic [3:0] code, output bit bad);
    code = 4'hF;
    bad  = 1'b1;
    for (int k = 0; k < 10; k++) if (seg_tab[k] == p) begin code = 4'(k); bad = 1'b0; end
    if (p == 7'b1111110) begin code = 4'hE; bad = 1'b0; end
    if (p == 7'b1111111) begin code = 4'hB; bad = 1'b0; end
  endtask

  task automatic model_reset(input int i);
    m_pan[i] = 4'hF; m_pcat[i] = 8'hFF; m_d[i] = 0;
    m_track[i] = 0; m_exp[i] = 0; m_tmo[i] = 0;
    for (int k = 0; k < 4; k++) begin
      m_sh[i][k] = 0; m_shdp[i][k] = 0; m_dig[i][k] = 0; m_dpo[i][k] = 0;
    end
    m_stb[i] = 0; m_lock[i] = 0; m_eo[i] = 0; m_ea[i] = 0; m_es[i] = 0;
  endtask

  // One clock edge: act on the previously latched pins and their dwell length
  task automatic model_edge(input int i, input logic [3:0] an, input logic [7:0] cat);
    int zeros = 0;
    int idx = 0;
    logic [3:0] code;
    bit bad;
    m_stb[i] = 0; m_eo[i] = 0; m_ea[i] = 0; m_es[i] = 0;
    for (int b = 0; b < 4; b++) if (!m_pan[i][b]) begin zeros++; idx = b; end
    decode(m_pcat[i][7:1], code, bad);
    if (zeros >= 2 && m_d[i] == 1) begin
      m_ea[i] = 1; m_lock[i] = 0; m_track[i] = 0; m_exp[i] = 0; m_tmo[i] = 0;
    end else if (zeros == 1 && m_d[i] == settle_of[i]) begin
      m_tmo[i] = 0;
      m_es[i] = bad;
      if (!m_track[i]) begin
        if (idx == 0) begin
          m_sh[i][0] = code; m_shdp[i][0] = !m_pcat[i][0]; m_exp[i] = 1; m_track[i] = 1;
        end
      end else if (idx == m_exp[i]) begin
        m_sh[i][idx] = code; m_shdp[i][idx] = !m_pcat[i][0];
        if (idx == 3) begin
          for (int k = 0; k < 4; k++) begin m_dig[i][k] = m_sh[i][k]; m_dpo[i][k] = m_shdp[i][k]; end
          m_stb[i] = 1; m_lock[i] = 1; m_exp[i] = 0;
        end else begin
          m_exp[i] = m_exp[i] + 1;
        end
      end else begin
        m_eo[i] = 1; m_lock[i] = 0;
        if (idx == 0) begin
          m_sh[i][0] = code; m_shdp[i][0] = !m_pcat[i][0]; m_exp[i] = 1;
        end else begin
          m_track[i] = 0; m_exp[i] = 0;
        end
      end
    end else if (m_track[i]) begin
      m_tmo[i]++;
      if (m_tmo[i] == c_TMO) begin
        m_track[i] = 0; m_lock[i] = 0; m_exp[i] = 0; m_tmo[i] = 0;
      end
    end
    m_d[i]    = (an == m_pan[i]) ? m_d[i] + 1 : 1;
    m_pan[i]  = an;
    m_pcat[i] = cat;
  endtask

  function automatic logic [24:0] model_pack(input int i);
    return {m_dig[i][3], m_dig[i][2], m_dig[i][1], m_dig[i][0],
            m_dpo[i][3], m_dpo[i][2], m_dpo[i][1], m_dpo[i][0],
            m_stb[i], m_lock[i], m_eo[i], m_ea[i], m_es[i]};
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      cnt_stb[i] = 0; cnt_eo[i] = 0; cnt_ea[i] = 0; cnt_es[i] = 0; first_stb[i] = -1;
    end
  endtask

  task automatic tick(input logic [3:0] an, input logic [7:0] cat, input bit r);
    anode = an; cathode = cat; rst = r;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) model_reset(i);
      else   model_edge(i, an, cat);
    end
    #1;
    check_eq("s1_outputs", 32'(w_pk1), 32'(model_pack(0)));
    check_eq("s3_outputs", 32'(w_pk3), 32'(model_pack(1)));
    if (s1_stb) begin cnt_stb[0]++; if (first_stb[0] < 0) first_stb[0] = cyc; end
    if (s3_stb) begin cnt_stb[1]++; if (first_stb[1] < 0) first_stb[1] = cyc; end
    if (s1_eo) cnt_eo[0]++;
    if (s3_eo) cnt_eo[1]++;
    if (s1_ea) cnt_ea[0]++;
    if (s3_ea) cnt_ea[1]++;
    if (s1_es) cnt_es[0]++;
    if (s3_es) cnt_es[1]++;
    cyc++;
  endtask

  task automatic show(input int d, input logic [6:0] pat, input bit dpon, input int hold);
    for (int k = 0; k < hold; k++) tick(an_tab[d], {pat, ~dpon}, 1'b0);
  endtask

  task automatic blank(input int hold);
    for (int k = 0; k < hold; k++) tick(4'hF, 8'hFF, 1'b0);
  endtask

  // Scan ones..thousands with numeric digits v0..v3
  task automatic rot(input int v0, input int v1, input int v2, input int v3, input int hold);
    show(0, seg_tab[v0], 1'b0, hold);
    show(1, seg_tab[v1], 1'b0, hold);
    show(2, seg_tab[v2], 1'b0, hold);
    show(3, seg_tab[v3], 1'b0, hold);
  endtask

  initial begin
    int thou_tick;
    int ord;
    for (int i = 0; i < 2; i++) model_reset(i);
    clear_counts();

    // Reset state
    tick(4'hF, 8'hFF, 1'b1);
    tick(4'hF, 8'hFF, 1'b1);
    check_eq("reset_s1", 32'(w_pk1), 32'h0);
    check_eq("reset_s3", 32'(w_pk3), 32'h0);
    blank(2);

    // Two rotations of 4,3,2,1; first strobe follows the first thousands dwell
    clear_counts();
    rot(1, 2, 3, 0, 0);
    show(0, seg_tab[1], 1'b0, 3);
    show(1, seg_tab[2], 1'b0, 3);
    show(2, seg_tab[3], 1'b0, 3);
    thou_tick = cyc;
    show(3, seg_tab[4], 1'b0, 3);
    rot(1, 2, 3, 4, 3);
    blank(3);
    check_eq("rot_latency_s1", 32'(first_stb[0] - thou_tick), 32'd1);
    check_eq("rot_latency_s3", 32'(first_stb[1] - thou_tick), 32'd3);
    check_eq("rot_frames_s1", 32'(cnt_stb[0]), 32'd2);
    check_eq("rot_digits_s1", {16'h0, s1_thou, s1_hund, s1_tens, s1_ones}, 32'h4321);
    check_eq("rot_digits_s3", {16'h0, s3_thou, s3_hund, s3_tens, s3_ones}, 32'h4321);
    check_eq("rot_locked_s1", 32'(s1_lock), 32'd1);

    // Order violation: ones, tens, thousands
    clear_counts();
    show(0, seg_tab[7], 1'b0, 3);
    show(1, seg_tab[7], 1'b0, 3);
    show(3, seg_tab[7], 1'b0, 3);
    blank(2);
    check_eq("order_err_s1", 32'(cnt_eo[0]), 32'd1);
    check_eq("order_err_s3", 32'(cnt_eo[1]), 32'd1);
    check_eq("order_lock_s1", 32'(s1_lock), 32'd0);
    check_eq("order_hold_s1", {16'h0, s1_thou, s1_hund, s1_tens, s1_ones}, 32'h4321);

    // Two anodes low for 3 cycles, then a tens sample is ignored in HUNT
    clear_counts();
    for (int k = 0; k < 3; k++) tick(4'b1100, {seg_tab[8], 1'b1}, 1'b0);
    blank(2);
    show(1, seg_tab[3], 1'b0, 3);
    blank(2);
    check_eq("anode_err_s1", 32'(cnt_ea[0]), 32'd1);
    check_eq("anode_err_s3", 32'(cnt_ea[1]), 32'd1);
    check_eq("hunt_ignore_s1", 32'(cnt_eo[0]), 32'd0);

    // Bad tens pattern, blank hundreds, dash thousands, dp on tens
    clear_counts();
    show(0, seg_tab[5], 1'b0, 3);
    show(1, 7'b1010101, 1'b1, 3);
    show(2, 7'b1111111, 1'b0, 3);
    show(3, 7'b1111110, 1'b0, 3);
    blank(2);
    check_eq("seg_err_s1", 32'(cnt_es[0]), 32'd1);
    check_eq("seg_frame_s3", 32'(cnt_stb[1]), 32'd1);
    check_eq("seg_digits_s1", {16'h0, s1_thou, s1_hund, s1_tens, s1_ones}, 32'hEBF5);
    check_eq("seg_dp_s1", 32'(s1_dp), 32'b0010);

    // SETTLE=3 instance: 2-cycle dwells give nothing, 3-cycle dwells commit
    clear_counts();
    rot(6, 7, 8, 9, 2);
    blank(2);
    check_eq("short_dwell_s3", 32'(cnt_stb[1] + cnt_eo[1] + cnt_es[1]), 32'd0);
    check_eq("short_dwell_s1", 32'(cnt_stb[0]), 32'd1);
    clear_counts();
    rot(6, 7, 8, 9, 3);
    blank(2);
    check_eq("long_dwell_s3", 32'(cnt_stb[1]), 32'd1);
    check_eq("long_digits_s3", {16'h0, s3_thou, s3_hund, s3_tens, s3_ones}, 32'h9876);

    // Reset after ones/tens captured
    clear_counts();
    show(0, seg_tab[1], 1'b0, 3);
    show(1, seg_tab[2], 1'b0, 3);
    tick(an_tab[2], {seg_tab[3], 1'b1}, 1'b1);
    check_eq("midrst_s1", 32'(w_pk1), 32'h0);
    check_eq("midrst_s3", 32'(w_pk3), 32'h0);
    show(2, seg_tab[3], 1'b0, 2);
    show(3, seg_tab[4], 1'b0, 3);
    blank(2);
    check_eq("midrst_nostb", 32'(cnt_stb[0] + cnt_stb[1]), 32'd0);
    rot(5, 6, 7, 8, 3);
    blank(2);
    check_eq("postrst_frame_s3", 32'(cnt_stb[1]), 32'd1);
    check_eq("postrst_digits_s1", {16'h0, s1_thou, s1_hund, s1_tens, s1_ones}, 32'h8765);

    // Randomized traffic, checked cycle-by-cycle against the model
    ord = 0;
    while (cyc < 4000) begin
      int sel;
      int hold;
      logic [6:0] pat;
      sel  = int'($urandom_range(0, 99));
      hold = int'($urandom_range(1, 5));
      if (sel < 70) begin
        int pr;
        pr = int'($urandom_range(0, 99));
        if (pr < 85)      pat = seg_tab[$urandom_range(0, 9)];
        else if (pr < 90) pat = 7'b1111110;
        else if (pr < 95) pat = 7'b1111111;
        else              pat = 7'($urandom);
        if ($urandom_range(0, 9) == 0) ord = int'($urandom_range(0, 3));
        show(ord, pat, 1'($urandom), hold);
        ord = (ord + 1) % 4;
      end else if (sel < 80) begin
        logic [3:0] an;
        an = 4'($urandom);
        for (int k = 0; k < hold; k++) tick(an, 8'($urandom), 1'b0);
      end else if (sel < 95) begin
        blank(int'($urandom_range(1, 10)));
      end else if (sel < 98) begin
        blank(c_TMO + 6);
      end else begin
        tick(4'($urandom), 8'($urandom), 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
